// File: rtl/disp_mode_pkg.sv
// Shared types and the next-mode helper for the display-mode scheduler.
`default_nettype none

package disp_mode_pkg;

  typedef enum logic [1:0] {
    MODE_DEFAULT = 2'd0,
    MODE_TIME    = 2'd1,
    MODE_WAVE    = 2'd2
  } disp_mode_t;

  typedef enum logic {
    S_HOLD = 1'b0,
    S_PEND = 1'b1
  } sched_state_t;

  // One step with wrap at mode_cnt; optionally hops over wave_mode (a single extra step at most).
  function automatic logic [1:0] next_mode(input logic [1:0] cur,
                                           input logic       skip_wave,
                                           input int         mode_cnt,
                                           input int         wave_mode);
    logic [1:0] n;
    n = (int'(cur) == mode_cnt - 1) ? 2'd0 : cur + 2'd1;
    if (skip_wave && (int'(n) == wave_mode)) begin
      n = (int'(n) == mode_cnt - 1) ? 2'd0 : n + 2'd1;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_edge_det.sv
// 1-bit rising-edge detector; RST_VAL seeds the history so a level held through reset is not an edge.
`default_nettype none

module rise_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/show_mode_sched.sv
// Display-mode scheduler: manual and dwell-timed mode advances, committed only on frame_start_i.
`default_nettype none

module show_mode_sched
  import disp_mode_pkg::*;
#(
  parameter int MODE_CNT     = 3,
  parameter int INIT_MODE    = 0,
  parameter int WAVE_MODE    = 2,
  parameter int DWELL_FRAMES = 600
) (
  input  logic       clk_25_i,
  input  logic       rst_i,
  input  logic       frame_start_i,
  input  logic       btn_next_i,
  input  logic       auto_en_i,
  input  logic       adc_active_i,
  output logic [1:0] show_mode_o,
  output logic       mode_chg_o,
  output logic       pending_o
);

  localparam int                DW         = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL_FRAMES - 1);

  sched_state_t  state_q;
  logic [1:0]    mode_q;
  logic          mode_chg_q;
  logic [DW-1:0] dwell_q;

  logic          press;
  logic          dwell_exp;
  logic          advance;
  logic          skip_wave;
  logic [1:0]    mode_d;

  rise_edge_det #(
    .RST_VAL (1'b1)
  ) u_btn_edge (
    .clk_i  (clk_25_i),
    .rst_i  (rst_i),
    .d_i    (btn_next_i),
    .rise_o (press)
  );

  always_comb begin
    dwell_exp = auto_en_i && (dwell_q == DWELL_LAST);
    advance   = frame_start_i && ((state_q == S_PEND) || dwell_exp);
    // Skipping is an auto-cycle behaviour only; a queued manual advance always takes one plain step.
    skip_wave = (state_q == S_HOLD) && !adc_active_i;
    mode_d    = next_mode(mode_q, skip_wave, MODE_CNT, WAVE_MODE);
  end

  always_ff @(posedge clk_25_i) begin
    if (rst_i) begin
      state_q    <= S_HOLD;
      mode_q     <= 2'(INIT_MODE);
      mode_chg_q <= 1'b0;
      dwell_q    <= '0;
    end else begin
      mode_chg_q <= 1'b0;
      if (advance) begin
        mode_q     <= mode_d;
        mode_chg_q <= 1'b1;
        dwell_q    <= '0;
        // A press coinciding with a dwell-driven commit from S_HOLD is queued for the next frame.
        state_q    <= (state_q == S_HOLD && press) ? S_PEND : S_HOLD;
      end else begin
        if (press && state_q == S_HOLD) begin
          state_q <= S_PEND;
        end
        if (!auto_en_i) begin
          dwell_q <= '0;
        end else if (frame_start_i) begin
          dwell_q <= dwell_q + 1'b1;
        end
      end
    end
  end

  assign show_mode_o = mode_q;
  assign mode_chg_o  = mode_chg_q;
  assign pending_o   = (state_q == S_PEND);

endmodule

`default_nettype wire
